// File: rtl/spot_finder_pkg.sv
// Shared definitions for the spot finder block RAM. The writer uses them
// (pixel packing, address range, FSM encoding) and so does the reader.
//
// Contents:
//   PIX_W, PIX_PER_WORD, WORD_W, ADDR_W  : pixel and BRAM geometry
//   VGA_KERNELS_X, VGA_LINES_Y           : default 640x480 camera geometry
//   wr_state_t                           : writer FSM encoding
//   geometry_ok()                        : frame size check against the BRAM depth
package spot_finder_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 32;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int ADDR_W       = 14;

  localparam int VGA_KERNELS_X = 20;
  localparam int VGA_LINES_Y   = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } wr_state_t;

  // A frame must have at least one word and must fit the BRAM exactly or
  // with room to spare. 2^addr_w words is still valid: the writer counts
  // words with one extra bit, so the last address does not wrap.
  function automatic logic geometry_ok(input logic [31:0] total, input int addr_w);
    logic [32:0] depth;
    depth = 33'd1 << addr_w;
    return (total != 32'd0) && ({1'b0, total} <= depth);
  endfunction

endpackage

// File: rtl/spot_ram_writer_pixel_packer.sv
// pixel_packer: assembles PIX_PER_WORD pixels into one BRAM kernel.
//
// Ports:
//   clk_in, reset : clock and synchronous active-high reset
//   clear         : drop any partial kernel and restart at slot 0
//   accept        : pix_data is part of the current frame this cycle
//   pix_data      : pixel value
//   word_valid    : combinational; this cycle's pixel completes a kernel
//   word_data     : kernel including this cycle's pixel (pixel k at [k*PIX_W +: PIX_W])
//
// word_valid/word_data are combinational so the owner can register the write
// on the same edge that samples the last pixel (write appears next cycle).
module pixel_packer #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 32,
  localparam int IDX_W       = $clog2(PIX_PER_WORD)
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [PIX_W-1:0]              pix_data,
  output logic                          word_valid,
  output logic [PIX_PER_WORD*PIX_W-1:0] word_data
);
  import spot_finder_pkg::*;

  logic [PIX_PER_WORD-1:0][PIX_W-1:0] pack_q, pack_d, pack_ins;
  logic [IDX_W-1:0]                   idx_q, idx_d;

  always_comb begin
    pack_ins = pack_q;
    if (accept) begin
      pack_ins[idx_q] = pix_data;
    end

    // A clear means this pixel (if any) is the first of a new frame, so it
    // never completes the old kernel.
    word_valid = accept && !clear && (idx_q == IDX_W'(PIX_PER_WORD - 1));
    word_data  = pack_ins;

    pack_d = pack_q;
    idx_d  = idx_q;
    if (clear) begin
      pack_d = '0;
      idx_d  = '0;
      if (accept) begin
        pack_d[0] = pix_data;
        idx_d     = IDX_W'(1);
      end
    end else if (accept) begin
      pack_d = pack_ins;
      idx_d  = idx_q + 1'b1;  // wraps to 0 after the last slot
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pack_q <= '0;
      idx_q  <= '0;
    end else begin
      pack_q <= pack_d;
      idx_q  <= idx_d;
    end
  end

endmodule

// File: rtl/spot_ram_writer.sv
// spot_ram_writer: write side of the spot finder BRAM.
// Packs the 8-bit pixel stream into 256-bit kernels, writes one kernel per
// address (line-major: address = line*cam_kernels_x + kernel), pulses
// frame_done after the last word, then holds until the reader releases the
// buffer so it never sees a partly overwritten image.
//
// Ports:
//   clk_in, reset     : clock and synchronous active-high reset
//   pix_data/pix_valid: pixel stream, at most one pixel per cycle
//   frame_start       : pulse with or before the first pixel of a frame
//   cam_kernels_x     : kernels per line
//   cam_lines_y       : lines per frame
//   buf_release       : spot finder analysis_rdy, buffer free for next frame
//   wr_en/wr_address/wr_data : BRAM write port (wr_data holds when idle)
//   frame_done        : one-cycle pulse after the last word is written
//   busy              : high while filling or holding
//   size_error        : sticky, last frame_start had invalid geometry
//   drop_count        : saturating count of discarded pixels
module spot_ram_writer #(
  parameter int PIX_PER_WORD = spot_finder_pkg::PIX_PER_WORD,
  parameter int ADDR_W       = spot_finder_pkg::ADDR_W,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                                          clk_in,
  input  logic                                          reset,
  input  logic [spot_finder_pkg::PIX_W-1:0]             pix_data,
  input  logic                                          pix_valid,
  input  logic                                          frame_start,
  input  logic [15:0]                                   cam_kernels_x,
  input  logic [15:0]                                   cam_lines_y,
  input  logic                                          buf_release,
  output logic                                          wr_en,
  output logic [ADDR_W-1:0]                             wr_address,
  output logic [spot_finder_pkg::PIX_W*PIX_PER_WORD-1:0] wr_data,
  output logic                                          frame_done,
  output logic                                          busy,
  output logic                                          size_error,
  output logic [DROP_CNT_W-1:0]                         drop_count
);
  import spot_finder_pkg::*;

  localparam int KW = PIX_W * PIX_PER_WORD;

  wr_state_t               state_q, state_d;
  logic [ADDR_W:0]         word_cnt_q, word_cnt_d;
  logic [ADDR_W:0]         total_q, total_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_address_q, wr_address_d;
  logic [KW-1:0]           wr_data_q, wr_data_d;
  logic                    done_pend_q, done_pend_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q, busy_d;
  logic                    size_error_q, size_error_d;
  logic [DROP_CNT_W-1:0]   drop_q, drop_d;

  logic [31:0]             geom_total;
  logic                    geom_ok;
  logic                    start_seen;
  logic                    restart;
  logic                    accept;
  logic                    word_valid;
  logic [KW-1:0]           word_data;

  always_comb begin
    geom_total = 32'(cam_kernels_x) * 32'(cam_lines_y);
    geom_ok    = geometry_ok(geom_total, ADDR_W);
    // HOLD ignores frame_start entirely; the buffer is still owned by the reader.
    start_seen = frame_start && (state_q != HOLD);
    restart    = start_seen && geom_ok;
    // A pixel coinciding with a valid frame_start is the first pixel of that frame.
    accept     = pix_valid && (restart || ((state_q == FILL) && !start_seen));
  end

  pixel_packer #(
    .PIX_W        (PIX_W),
    .PIX_PER_WORD (PIX_PER_WORD)
  ) u_packer (
    .clk_in     (clk_in),
    .reset      (reset),
    .clear      (start_seen),
    .accept     (accept),
    .pix_data   (pix_data),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    total_d      = total_q;
    wr_en_d      = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d    = wr_data_q;
    done_pend_d  = 1'b0;
    // frame_done trails the final write by one cycle.
    frame_done_d = done_pend_q;
    size_error_d = size_error_q;
    drop_d       = drop_q;

    if (pix_valid && !accept && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end

    case (state_q)
      IDLE, FILL: begin
        if (start_seen) begin
          // Any write already registered still goes out; only the partial
          // kernel and the word position of the old frame are abandoned.
          if (geom_ok) begin
            state_d      = FILL;
            size_error_d = 1'b0;
            total_d      = geom_total[ADDR_W:0];
            word_cnt_d   = '0;
          end else begin
            state_d      = IDLE;
            size_error_d = 1'b1;
          end
        end else if ((state_q == FILL) && word_valid) begin
          wr_en_d      = 1'b1;
          wr_data_d    = word_data;
          wr_address_d = word_cnt_q[ADDR_W-1:0];
          word_cnt_d   = word_cnt_q + 1'b1;
          if ((word_cnt_q + 1'b1) == total_q) begin
            done_pend_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        // Let frame_done go out before handing the buffer back.
        if (buf_release && !done_pend_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      total_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_address_q <= '0;
      wr_data_q    <= '0;
      done_pend_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      size_error_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      total_q      <= total_d;
      wr_en_q      <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q    <= wr_data_d;
      done_pend_q  <= done_pend_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      size_error_q <= size_error_d;
      drop_q       <= drop_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_address = wr_address_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign size_error = size_error_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spot_ram_writer.sv
module tb_spot_ram_writer;

  logic         clk_in = 1'b0;
  logic         reset;
  logic [7:0]   pix_data;
  logic         pix_valid;
  logic         frame_start;
  logic [15:0]  cam_kernels_x;
  logic [15:0]  cam_lines_y;
  logic         buf_release;
  logic         wr_en;
  logic [13:0]  wr_address;
  logic [255:0] wr_data;
  logic         frame_done;
  logic         busy;
  logic         size_error;
  logic [15:0]  drop_count;

  spot_ram_writer dut (
    .clk_in        (clk_in),
    .reset         (reset),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .frame_start   (frame_start),
    .cam_kernels_x (cam_kernels_x),
    .cam_lines_y   (cam_lines_y),
    .buf_release   (buf_release),
    .wr_en         (wr_en),
    .wr_address    (wr_address),
    .wr_data       (wr_data),
    .frame_done    (frame_done),
    .busy          (busy),
    .size_error    (size_error),
    .drop_count    (drop_count)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [13:0]  a;
    logic [255:0] d;
    int           c;
  } wr_t;

  wr_t exp_q[$];

  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int failed = 0;
  int done_cnt = 0;
  int last_wr_cyc = -10;
  int last_wr_addr = -5;
  int exp_last = -1;
  logic [255:0] w0_data = '0;
  bit w0_seen = 0;

  // reference model state
  logic [255:0] mk;
  int mi, maddr, mtotal;
  bit mact = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cycle the bench knows whether a write and a
  // frame_done are due, and what they must carry.
  always @(negedge clk_in) begin
    wr_t e;
    logic exp_wr;
    logic exp_fd;
    while (exp_q.size() > 0 && exp_q[0].c < cyc) e = exp_q.pop_front();
    exp_wr = (exp_q.size() > 0) && (exp_q[0].c == cyc);
    check("wr_en", {255'd0, wr_en}, {255'd0, exp_wr});
    if (exp_wr) begin
      e = exp_q.pop_front();
      check("wr_address", {242'd0, wr_address}, {242'd0, e.a});
      check("wr_data", wr_data, e.d);
      if (!w0_seen) begin
        w0_data = wr_data;
        w0_seen = 1;
      end
    end
    exp_fd = (cyc == last_wr_cyc + 1) && (last_wr_addr == exp_last);
    check("frame_done", {255'd0, frame_done}, {255'd0, exp_fd});
    if (frame_done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      last_wr_addr = int'(wr_address);
    end
  end

  task automatic model_pix(input logic [7:0] d);
    wr_t e;
    if (mact) begin
      mk[mi*8 +: 8] = d;
      mi++;
      if (mi == 32) begin
        e.a = 14'(maddr);
        e.d = mk;
        e.c = cyc + 1;
        exp_q.push_back(e);
        maddr++;
        mi = 0;
        if (maddr == mtotal) mact = 0;
      end
    end
  endtask

  task automatic idle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic px(input logic [7:0] d);
    model_pix(d);
    pix_data = d;
    pix_valid = 1'b1;
    @(posedge clk_in);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic start(input int kx, input int ly, input bit wp, input logic [7:0] d);
    longint tot;
    cam_kernels_x = 16'(kx);
    cam_lines_y = 16'(ly);
    tot = longint'(kx) * longint'(ly);
    if (tot > 0 && tot <= 16384) begin
      mact = 1;
      mi = 0;
      maddr = 0;
      mtotal = int'(tot);
      exp_last = int'(tot) - 1;
      mk = '0;
    end else begin
      mact = 0;
    end
    if (wp) model_pix(d);
    frame_start = 1'b1;
    pix_valid = wp;
    pix_data = d;
    @(posedge clk_in);
    #1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
  endtask

  task automatic release_buf();
    buf_release = 1'b1;
    @(posedge clk_in);
    #1;
    buf_release = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {255'd0, wr_en}, 256'd0);
    check({tag, "_wr_address"}, {242'd0, wr_address}, 256'd0);
    check({tag, "_wr_data"}, wr_data, 256'd0);
    check({tag, "_frame_done"}, {255'd0, frame_done}, 256'd0);
    check({tag, "_busy"}, {255'd0, busy}, 256'd0);
    check({tag, "_size_error"}, {255'd0, size_error}, 256'd0);
    check({tag, "_drop_count"}, {240'd0, drop_count}, 256'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pix_data = '0;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    cam_kernels_x = '0;
    cam_lines_y = '0;
    buf_release = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    idle();

    // 2x2 frame, contiguous pixels p = i
    start(2, 2, 1, 8'h00);
    for (int i = 1; i < 128; i++) px(8'(i));
    repeat (4) idle();
    check("f1_done_cnt", 256'(done_cnt), 256'd1);
    check("f1_w0_lsb", {248'd0, w0_data[7:0]}, 256'h00);
    check("f1_w0_msb", {248'd0, w0_data[255:248]}, 256'h1F);
    check("f1_busy_hold", {255'd0, busy}, 256'd1);

    // HOLD: pixels and a frame_start are dropped
    for (int i = 0; i < 10; i++) begin
      if (i == 4) frame_start = 1'b1;
      px(8'hEE);
      frame_start = 1'b0;
    end
    frame_start = 1'b1;
    idle();
    frame_start = 1'b0;
    repeat (2) idle();
    check("hold_drop_count", {240'd0, drop_count}, 256'd10);
    check("hold_busy", {255'd0, busy}, 256'd1);
    release_buf();
    idle();
    check("release_busy", {255'd0, busy}, 256'd0);

    // same frame with pix_valid 1 of every 3 cycles
    start(2, 2, 0, 8'h00);
    for (int i = 0; i < 128; i++) begin
      px(8'(i));
      idle();
      idle();
    end
    repeat (2) idle();
    check("gap_done_cnt", 256'(done_cnt), 256'd2);
    release_buf();

    // abort after 70 pixels, restart with a pixel in the frame_start cycle
    start(2, 2, 0, 8'h00);
    for (int i = 0; i < 70; i++) px(8'(i + 16));
    start(2, 2, 1, 8'hC8);
    for (int i = 1; i < 128; i++) px(8'(200 + i));
    repeat (4) idle();
    check("abort_done_cnt", 256'(done_cnt), 256'd3);
    release_buf();
    idle();

    // geometry errors
    start(0, 480, 0, 8'h00);
    check("geom_0x480_err", {255'd0, size_error}, 256'd1);
    check("geom_0x480_busy", {255'd0, busy}, 256'd0);
    start(600, 30, 0, 8'h00);
    check("geom_600x30_err", {255'd0, size_error}, 256'd1);
    check("geom_600x30_busy", {255'd0, busy}, 256'd0);
    start(1, 16385, 0, 8'h00);
    check("geom_16385_err", {255'd0, size_error}, 256'd1);
    start(1, 16384, 0, 8'h00);
    check("geom_16384_err", {255'd0, size_error}, 256'd0);
    check("geom_16384_busy", {255'd0, busy}, 256'd1);
    start(2, 480, 0, 8'h00);
    start(20, 480, 0, 8'h00);
    check("vga_err_clear", {255'd0, size_error}, 256'd0);
    check("vga_busy", {255'd0, busy}, 256'd1);

    // one kernel then reset 15 pixels into the next
    for (int i = 0; i < 47; i++) px(8'(i * 3));
    reset = 1'b1;
    mact = 0;
    idle();
    check_reset_outputs("midrst");
    reset = 1'b0;
    idle();

    // clean frame after reset
    start(2, 2, 1, 8'hA5);
    for (int i = 1; i < 128; i++) px(8'(i) ^ 8'hA5);
    repeat (4) idle();
    check("post_rst_done_cnt", 256'(done_cnt), 256'd4);
    check("queue_empty", 256'(exp_q.size()), 256'd0);
    check("final_busy", {255'd0, busy}, 256'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spot_ram_writer.md
Name: spot_ram_writer

Overview:
- Write side of the spot finder block RAM: packs the 8-bit camera pixel stream into 256-bit kernels (32 pixels) and writes one kernel per BRAM address, line by line.
- Signals frame completion to the spot finder.
- Holds off the next frame until the spot finder releases the buffer (analysis ready), so the reader never sees a partially overwritten image.

Parameters:
- PIX_PER_WORD, 32, pixels packed per BRAM word (fixed by 256-bit data width)
- ADDR_W, 14, BRAM address width (max 16384 words)
- DROP_CNT_W, 16, width of dropped-pixel counter

Ports:
- clk_in  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_data  in  8  pixel value, valid when pix_valid=1
- pix_valid  in  1  pixel strobe, one pixel per cycle max
- frame_start  in  1  one-cycle pulse coinciding with or preceding the first pixel of a frame
- cam_kernels_x  in  16  kernels per line (line width / 32)
- cam_lines_y  in  16  lines per frame
- release  in  1  spot finder analysis_rdy; buffer free for the next frame
- wr_en  out  1  BRAM write enable
- wr_address  out  ADDR_W  BRAM write address
- wr_data  out  256  packed kernel; pixel k at bits [8k +: 8]
- frame_done  out  1  one-cycle pulse after the last word of a frame is written
- busy  out  1  high in FILL and HOLD
- size_error  out  1  sticky; frame geometry invalid
- drop_count  out  DROP_CNT_W  saturating count of discarded pixels

Behaviour:
- Reset values:
  - wr_en=0, wr_address=0, wr_data=0, frame_done=0, busy=0, size_error=0, drop_count=0
  - pixel index=0, word count=0, state=IDLE.
- Geometry:
  - total = cam_kernels_x*cam_lines_y, computed at 32-bit width and latched on frame_start.
  - If total==0 or total>2^ADDR_W: set size_error, stay in IDLE.
  - A valid frame_start clears size_error.
- States:
  - IDLE: on frame_start with valid geometry -> FILL; pixel index=0, next address=0. A pixel with pix_valid in the same cycle as frame_start is the first pixel.
  - FILL:
    - Each pix_valid writes pix_data into the shift/pack register at slot pixel index, then index+1.
    - On the 32nd pixel (index==31), the next cycle has wr_en=1, wr_data=full kernel, wr_address=current word address. Address then increments and index returns to 0.
    - Latency: wr_en exactly 1 cycle after the 32nd pixel is sampled.
    - Back-to-back kernels: pixels arriving during the write cycle are accepted into the next kernel without loss.
    - After the write of address total-1: frame_done=1 for 1 cycle -> HOLD.
  - HOLD:
    - busy=1; all pix_valid dropped (drop_count+1 each, saturating at all-ones).
    - On release=1 -> IDLE.
    - frame_start is ignored in HOLD and counted only via dropped pixels.
- Boundaries:
  - frame_start during FILL:
    - The partial frame is abandoned with no frame_done.
    - Restart at address 0 with geometry re-latched; a pending partial kernel is discarded.
    - If the same cycle would also write a word, the write still completes.
  - pix_valid in IDLE without frame_start: dropped, counted.
  - Reset mid-frame: all state cleared, no write issued that cycle.
  - release high in IDLE/FILL: no effect.
- Arithmetic:
  - Address compare uses a word counter of ADDR_W+1 bits, so total=16384 ends without wrap.
  - pixel index is 5 bits and wraps naturally after 31.
  - Lines are implicit: each line occupies cam_kernels_x consecutive addresses (address = line*cam_kernels_x + kernel).
- Outputs are all registered; wr_data holds its last value while wr_en=0.

Decomposition:
- Shared package spot_finder_pkg:
  - PIX_W=8, PIX_PER_WORD=32, WORD_W=256, ADDR_W=14
  - state encodings IDLE/FILL/HOLD
  - VGA defaults: 20 kernels, 480 lines.
  - The spot finder reader uses the same package.
- One natural sub-module: pixel_packer. It holds the 32-slot pack register, pixel index and word_valid pulse, with a clear input driven by frame_start/reset. The FSM and address logic stay in the top.

Test Plan:
- Geometry 2x2, 128 consecutive pixels of value p=i%256 after frame_start -> 4 writes.
  - Addresses 0..3; word 0 bits[7:0]=0x00 and bits[255:248]=0x1F.
  - frame_done 1 cycle after the write to address 3; busy stays 1 until release.
- Same frame with pix_valid gaps (1 of every 3 cycles) -> identical words and addresses; wr_en 1 cycle after each 32nd pixel.
- In HOLD, 10 pixels plus one frame_start -> no writes, drop_count=10.
  - After release, a new frame_start -> writes restart at address 0.
- frame_start after 70 pixels of a 2x2 frame, then 128 new pixels:
  - 2 writes (addresses 0,1) from the aborted frame.
  - Then 4 writes at 0..3 with the new data; only one frame_done.
- Geometry 0x480 and 600x30 (18000 words) -> size_error=1, no writes, busy=0.
  - Valid 20x480 frame_start clears size_error; 307200 pixels -> last write at address 9599, then frame_done.
- Reset asserted mid-kernel (15 pixels in) -> all outputs at reset values next cycle.
  - The following frame's first write is at address 0 with clean data.
